regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the architectural/physical register file built from the 2-read/2-write synchronous no-latch RAMs. Four execution-unit write-back requesters compete for the two RAM write ports. Each cycle the block:
- selects up to two requests;
- never grants two writes to the same non-zero address in one cycle;
- drops writes to register 0;
- registers the winners onto `we1/waddr1/wdata1` and `we2/waddr2/wdata2` one cycle later.

---
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the four execution-unit requesters and the register-file arbiter.
// The master side is the requesters; the slave side is the arbiter driving the RAM write ports.
interface regfile_wb_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic [3:0]          req_valid;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_data;
    logic [3:0]          req_ready;
    logic                we1;
    logic [ADDR_W-1:0]   waddr1;
    logic [DATA_W-1:0]   wdata1;
    logic                we2;
    logic [ADDR_W-1:0]   waddr2;
    logic [DATA_W-1:0]   wdata2;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, we1, waddr1, wdata1, we2, waddr2, wdata2
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, we1, waddr1, wdata1, we2, waddr2, wdata2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Picks up to two conflict-free write-backs per cycle for the 2-write-port register RAM.
// Define REGFILE_WB_RR_EN for a round-robin scan start; otherwise requester 0 has fixed priority.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 flush,
    regfile_wb_arbiter_if.slave wb
);
    logic [ADDR_W-1:0] addr [4];
    logic [DATA_W-1:0] data [4];
    logic [1:0]        ptr;
    logic              s1_vld;
    logic              s2_vld;
    logic [1:0]        s1_idx;
    logic [1:0]        s2_idx;
    logic [3:0]        ready;

    logic              we1_q;
    logic              we2_q;
    logic [ADDR_W-1:0] waddr1_q;
    logic [ADDR_W-1:0] waddr2_q;
    logic [DATA_W-1:0] wdata1_q;
    logic [DATA_W-1:0] wdata2_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr[i] = wb.req_addr[i*ADDR_W +: ADDR_W];
            data[i] = wb.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Slot 1 is claimed first in scan order, so slot 2 always lies after it.
    always_comb begin : sel
        logic [1:0] idx;
        idx    = 2'd0;
        s1_vld = 1'b0;
        s1_idx = 2'd0;
        s2_vld = 1'b0;
        s2_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (wb.req_valid[idx]) begin
                if (!s1_vld) begin
                    s1_vld = 1'b1;
                    s1_idx = idx;
                end else if (!s2_vld && (addr[idx] != addr[s1_idx] || addr[idx] == '0 ||
                                         addr[s1_idx] == '0)) begin
                    s2_vld = 1'b1;
                    s2_idx = idx;
                end
            end
        end
    end

    always_comb begin
        ready = 4'b0000;
        if (!flush && !reset) begin
            if (s1_vld) ready[s1_idx] = 1'b1;
            if (s2_vld) ready[s2_idx] = 1'b1;
        end
    end

    assign wb.req_ready = ready;

`ifdef REGFILE_WB_RR_EN
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (!flush) begin
            if (s2_vld) begin
                ptr_d = s2_idx + 2'd1;
            end else if (s1_vld) begin
                ptr_d = s1_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 2'd0;
`endif

    // Register-0 writes are granted but never reach the RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we1_q    <= 1'b0;
            we2_q    <= 1'b0;
            waddr1_q <= '0;
            waddr2_q <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
        end else if (flush) begin
            we1_q <= 1'b0;
            we2_q <= 1'b0;
        end else begin
            we1_q <= s1_vld && (addr[s1_idx] != '0);
            we2_q <= s2_vld && (addr[s2_idx] != '0);
            if (s1_vld) begin
                waddr1_q <= addr[s1_idx];
                wdata1_q <= data[s1_idx];
            end
            if (s2_vld) begin
                waddr2_q <= addr[s2_idx];
                wdata2_q <= data[s2_idx];
            end
        end
    end

    assign wb.we1    = we1_q;
    assign wb.we2    = we2_q;
    assign wb.waddr1 = waddr1_q;
    assign wb.waddr2 = waddr2_q;
    assign wb.wdata1 = wdata1_q;
    assign wb.wdata2 = wdata2_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset, conflict, round-robin and flush
// sequences. Round-robin expectations follow REGFILE_WB_RR_EN.
module tb_regfile_wb_arbiter;
    logic clk;
    logic reset;
    logic flush;
    int   total;
    int   bad;

    regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [4:0]  a3;
        logic [4:0]  a2;
        logic [4:0]  a1;
        logic [4:0]  a0;
        logic [3:0]  ready;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        we2;
        logic [4:0]  wa2;
        logic [31:0] wd2;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid = 4'b0000;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        flush         = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();

        // valid, a3..a0, ready, we1/wa1/wd1, we2/wa2/wd2; data of req i in vector v = DA7A_vv0i
        vecs[0]  = '{4'b0101, 5'd0, 5'd7, 5'd0, 5'd3, 4'b0101,
                     1'b1, 5'd3, 32'hDA7A_0000, 1'b1, 5'd7, 32'hDA7A_0002};
        vecs[1]  = '{4'b0111, 5'd0, 5'd9, 5'd5, 5'd5, 4'b0101,
                     1'b1, 5'd5, 32'hDA7A_0100, 1'b1, 5'd9, 32'hDA7A_0102};
        vecs[2]  = '{4'b0110, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0110,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0};
        vecs[3]  = '{4'b1111, 5'd4, 5'd3, 5'd2, 5'd1, 4'b0011,
                     1'b1, 5'd1, 32'hDA7A_0300, 1'b1, 5'd2, 32'hDA7A_0301};
        vecs[4]  = '{4'b0000, 5'd1, 5'd2, 5'd3, 5'd4, 4'b0000,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0};
        vecs[5]  = '{4'b1000, 5'd12, 5'd0, 5'd0, 5'd0, 4'b1000,
                     1'b1, 5'd12, 32'hDA7A_0503, 1'b0, 5'd0, 32'h0};
        vecs[6]  = '{4'b0011, 5'd0, 5'd0, 5'd6, 5'd0, 4'b0011,
                     1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hDA7A_0601};
        vecs[7]  = '{4'b1010, 5'd8, 5'd0, 5'd8, 5'd0, 4'b0010,
                     1'b1, 5'd8, 32'hDA7A_0701, 1'b0, 5'd0, 32'h0};
        vecs[8]  = '{4'b1100, 5'd0, 5'd4, 5'd0, 5'd0, 4'b1100,
                     1'b1, 5'd4, 32'hDA7A_0802, 1'b0, 5'd0, 32'h0};
        vecs[9]  = '{4'b0101, 5'd0, 5'd7, 5'd0, 5'd7, 4'b0001,
                     1'b1, 5'd7, 32'hDA7A_0900, 1'b0, 5'd0, 32'h0};
        vecs[10] = '{4'b1110, 5'd5, 5'd0, 5'd5, 5'd0, 4'b0110,
                     1'b1, 5'd5, 32'hDA7A_0A01, 1'b0, 5'd0, 32'h0};

        #12;
        chk("reset_ready", 64'(bus.req_ready), 64'h0);
        chk("reset_we", 64'({bus.we1, bus.we2}), 64'h0);
        chk("reset_wdata1", 64'(bus.wdata1), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table: each vector starts from a freshly reset pointer.
        for (int v = 0; v < 11; v++) begin
            pulse_reset();
            bus.req_valid = vecs[v].valid;
            bus.req_addr  = {vecs[v].a3, vecs[v].a2, vecs[v].a1, vecs[v].a0};
            for (int i = 0; i < 4; i++) begin
                bus.req_data[i*32 +: 32] = 32'hDA7A_0000 | 32'(v << 8) | 32'(i);
            end
            #1;
            chk($sformatf("v%0d_ready", v), 64'(bus.req_ready), 64'(vecs[v].ready));
            tick();
            bus.req_valid = 4'b0000;
            chk($sformatf("v%0d_we1", v), 64'(bus.we1), 64'(vecs[v].we1));
            chk($sformatf("v%0d_we2", v), 64'(bus.we2), 64'(vecs[v].we2));
            if (vecs[v].we1) begin
                chk($sformatf("v%0d_waddr1", v), 64'(bus.waddr1), 64'(vecs[v].wa1));
                chk($sformatf("v%0d_wdata1", v), 64'(bus.wdata1), 64'(vecs[v].wd1));
            end
            if (vecs[v].we2) begin
                chk($sformatf("v%0d_waddr2", v), 64'(bus.waddr2), 64'(vecs[v].wa2));
                chk($sformatf("v%0d_wdata2", v), 64'(bus.wdata2), 64'(vecs[v].wd2));
            end
        end

        // Mid-stream reset with four requests pending.
        pulse_reset();
        bus.req_valid = 4'b1111;
        bus.req_addr  = {5'd14, 5'd13, 5'd12, 5'd11};
        bus.req_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ready", 64'(bus.req_ready), 64'h0);
        chk("midrst_we", 64'({bus.we1, bus.we2}), 64'h0);
        chk("midrst_waddr", 64'({bus.waddr1, bus.waddr2}), 64'h0);
        chk("midrst_wdata", 64'({bus.wdata1, bus.wdata2}), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postrst_ready", 64'(bus.req_ready), 64'b0011);

        // Same-address trio: one grant per cycle, requesters drop once granted.
        pulse_reset();
        bus.req_valid = 4'b0111;
        bus.req_addr  = {5'd0, 5'd5, 5'd5, 5'd5};
        bus.req_data  = {32'h0, 32'hC0C0_0002, 32'hC0C0_0001, 32'hC0C0_0000};
        for (int c = 0; c < 3; c++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0001 << c;
            #1;
            chk($sformatf("trio%0d_ready", c), 64'(bus.req_ready), 64'(exp_rdy));
            tick();
            bus.req_valid = bus.req_valid & ~exp_rdy;
            chk($sformatf("trio%0d_we", c), 64'({bus.we1, bus.we2}), 64'b10);
            chk($sformatf("trio%0d_wdata1", c), 64'(bus.wdata1), 64'(32'hC0C0_0000 + 32'(c)));
        end

        // Round-robin: four requesters held valid for four cycles.
        pulse_reset();
        bus.req_valid = 4'b1111;
        bus.req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        for (int c = 0; c < 4; c++) begin
            logic [3:0] exp_rdy;
`ifdef REGFILE_WB_RR_EN
            exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
`else
            exp_rdy = 4'b0011;
`endif
            #1;
            chk($sformatf("rr%0d_ready", c), 64'(bus.req_ready), 64'(exp_rdy));
            tick();
        end

        // Flush with pending outputs and two valid requests.
        pulse_reset();
        bus.req_valid = 4'b0101;
        bus.req_addr  = {5'd0, 5'd7, 5'd0, 5'd3};
        bus.req_data  = {32'h0, 32'hBBBB_0002, 32'h0, 32'hAAAA_0001};
        #1;
        chk("dual_ready", 64'(bus.req_ready), 64'b0101);
        tick();
        chk("dual_port1", 64'({bus.we1, bus.waddr1, bus.wdata1}), {26'h0, 1'b1, 5'd3, 32'hAAAA_0001});
        chk("dual_port2", 64'({bus.we2, bus.waddr2, bus.wdata2}), {26'h0, 1'b1, 5'd7, 32'hBBBB_0002});
        flush = 1'b1;
        #1;
        chk("flush_ready", 64'(bus.req_ready), 64'h0);
        tick();
        chk("flush_we", 64'({bus.we1, bus.we2}), 64'h0);
        flush = 1'b0;
        #1;
        chk("postflush_ready", 64'(bus.req_ready), 64'b0101);
        tick();
        chk("postflush_port1", 64'({bus.we1, bus.waddr1, bus.wdata1}),
            {26'h0, 1'b1, 5'd3, 32'hAAAA_0001});
        chk("postflush_port2", 64'({bus.we2, bus.waddr2, bus.wdata2}),
            {26'h0, 1'b1, 5'd7, 32'hBBBB_0002});
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
